// File: rtl/xdma_stream_arbiter_if.sv
// Stream bundle shared by the difftest packers, the packet arbiter and the XDMA
// host channel sink. The arbiter takes the slave view, the environment the master view.
interface xdma_stream_arbiter_if #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 512
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH*DATA_WIDTH-1:0] in_tdata;
    logic [NUM_CH-1:0]            in_tlast;
    logic [NUM_CH-1:0]            in_tvalid;
    logic [NUM_CH-1:0]            in_tready;
    logic [DATA_WIDTH-1:0]        out_tdata;
    logic                         out_tlast;
    logic                         out_tvalid;
    logic                         out_tready;
    logic [CH_W-1:0]              out_tchannel;
    logic                         busy;
    logic                         err_overlong;
    logic [31:0]                  pkt_count;

    // Producers and sink drive the request side and the sink ready.
    modport master (
        output in_tdata,
        output in_tlast,
        output in_tvalid,
        input  in_tready,
        input  out_tdata,
        input  out_tlast,
        input  out_tvalid,
        output out_tready,
        input  out_tchannel,
        input  busy,
        input  err_overlong,
        input  pkt_count
    );

    modport slave (
        input  in_tdata,
        input  in_tlast,
        input  in_tvalid,
        output in_tready,
        output out_tdata,
        output out_tlast,
        output out_tvalid,
        input  out_tready,
        output out_tchannel,
        output busy,
        output err_overlong,
        output pkt_count
    );
endinterface

// File: rtl/xdma_stream_arbiter.sv
// Packet-atomic round-robin arbiter sharing one XDMA AXI-stream host channel between
// NUM_CH difftest producers; the granted channel index travels with every beat.
module xdma_stream_arbiter #(
    parameter  int NUM_CH     = 4,
    parameter  int DATA_WIDTH = 512,
    parameter  int MAX_BEATS  = 64,
    localparam int CH_W       = $clog2(NUM_CH)
) (
    input  logic                 clock,
    input  logic                 reset,
    xdma_stream_arbiter_if.slave bus
);
    localparam int BEAT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CH_W-1:0]         grant_r;
    logic [CH_W-1:0]         rr_ptr_r;
    logic [BEAT_W-1:0]       beat_cnt_r;
    logic                    err_overlong_r;
    logic [31:0]             pkt_count_r;

    logic [CH_W-1:0]         winner_s;
    logic [CH_W-1:0]         cand_s;
    logic                    any_req_s;
    logic                    boundary_s;
    logic                    fire_s;
    logic                    last_fire_s;
    logic                    overlong_s;
    logic [NUM_CH-1:0]       in_tready_s;
    logic [DATA_WIDTH-1:0]   out_tdata_s;
    logic                    out_tlast_s;
    logic                    out_tvalid_s;

    // Channel index base+off, wrapped modulo NUM_CH (NUM_CH need not be a power of two).
    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
        logic [CH_W:0] sum;
        sum = {1'b0, base} + (CH_W+1)'(off);
        if (sum >= (CH_W+1)'(NUM_CH)) begin
            sum = sum - (CH_W+1)'(NUM_CH);
        end else begin
            sum = sum;
        end
        return sum[CH_W-1:0];
    endfunction

    // Round-robin search: first requesting channel starting at rr_ptr.
    always_comb begin
        winner_s  = rr_ptr_r;
        any_req_s = 1'b0;
        cand_s    = rr_ptr_r;
        for (int k = 0; k < NUM_CH; k++) begin
            cand_s = wrap_add(rr_ptr_r, k);
            if (!any_req_s && bus.in_tvalid[cand_s]) begin
                winner_s  = cand_s;
                any_req_s = 1'b1;
            end else begin
                winner_s  = winner_s;
                any_req_s = any_req_s;
            end
        end
    end

    assign boundary_s = (beat_cnt_r == BEAT_W'(MAX_BEATS - 1));

    // Next-state decode plus the zero-latency datapath from the granted channel to the sink.
    always_comb begin
        state_nxt_s  = state_r;
        in_tready_s  = '0;
        out_tdata_s  = '0;
        out_tlast_s  = 1'b0;
        out_tvalid_s = 1'b0;
        fire_s       = 1'b0;
        last_fire_s  = 1'b0;
        overlong_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                out_tvalid_s         = bus.in_tvalid[grant_r];
                out_tdata_s          = bus.in_tdata[grant_r*DATA_WIDTH +: DATA_WIDTH];
                out_tlast_s          = bus.in_tlast[grant_r] | boundary_s;
                in_tready_s[grant_r] = bus.out_tready;
                fire_s               = out_tvalid_s & bus.out_tready;
                last_fire_s          = fire_s & out_tlast_s;
                overlong_s           = last_fire_s & boundary_s & ~bus.in_tlast[grant_r];
                if (last_fire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant, round-robin pointer, beat counter and status registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_r        <= CH_W'(0);
            rr_ptr_r       <= CH_W'(0);
            beat_cnt_r     <= BEAT_W'(0);
            err_overlong_r <= 1'b0;
            pkt_count_r    <= 32'd0;
        end else begin
            if (state_r == ST_IDLE && any_req_s) begin
                grant_r    <= winner_s;
                beat_cnt_r <= BEAT_W'(0);
            end else if (last_fire_s) begin
                rr_ptr_r    <= wrap_add(grant_r, 1);
                beat_cnt_r  <= BEAT_W'(0);
                pkt_count_r <= pkt_count_r + 32'd1;
            end else if (fire_s) begin
                beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
            end
            // A forced termination is sticky until the next reset.
            if (overlong_s) begin
                err_overlong_r <= 1'b1;
            end
        end
    end

    assign bus.in_tready    = in_tready_s;
    assign bus.out_tdata    = out_tdata_s;
    assign bus.out_tlast    = out_tlast_s;
    assign bus.out_tvalid   = out_tvalid_s;
    assign bus.out_tchannel = grant_r;
    assign bus.busy         = (state_r == ST_BUSY);
    assign bus.err_overlong = err_overlong_r;
    assign bus.pkt_count    = pkt_count_r;
endmodule

// File: tb/tb_xdma_stream_arbiter.sv
// Directed bench for xdma_stream_arbiter: per-channel producer model driving tagged
// beats, with expectations written per scenario.
module tb_xdma_stream_arbiter;
    localparam int NUM_CH = 4;
    localparam int DW     = 512;
    localparam int MAXB   = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    xdma_stream_arbiter_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) bus ();

    xdma_stream_arbiter #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .MAX_BEATS(MAXB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int plen [NUM_CH];
    int beat [NUM_CH];
    int pkt  [NUM_CH];
    int npk  [NUM_CH];

    // Beat tag: channel in the top byte and byte 1, packet number at byte 32, beat in byte 0.
    function automatic logic [DW-1:0] mk(input int c, input int p, input int b);
        logic [DW-1:0] v;
        v            = '0;
        v[DW-1 -: 8] = 8'(c);
        v[263:256]   = 8'(p);
        v[15:8]      = 8'(c);
        v[7:0]       = 8'(b);
        return v;
    endfunction

    task automatic drive_inputs();
        for (int c = 0; c < NUM_CH; c++) begin
            logic en;
            en                    = (pkt[c] < npk[c]);
            bus.in_tvalid[c]      = en;
            bus.in_tlast[c]       = en && (beat[c] == plen[c] - 1);
            bus.in_tdata[c*DW +: DW] = en ? mk(c, pkt[c], beat[c]) : '0;
        end
    endtask

    // Producers advance only on beats that really handshook before this edge.
    task automatic cycle_end();
        logic [NUM_CH-1:0] fire;
        fire = bus.in_tready & bus.in_tvalid;
        @(posedge clock);
        for (int c = 0; c < NUM_CH; c++) begin
            if (fire[c]) begin
                if (beat[c] == plen[c] - 1) begin
                    beat[c] = 0;
                    pkt[c]  = pkt[c] + 1;
                end else begin
                    beat[c] = beat[c] + 1;
                end
            end
        end
        #2;
    endtask

    task automatic clear_model();
        for (int c = 0; c < NUM_CH; c++) begin
            beat[c] = 0;
            pkt[c]  = 0;
            npk[c]  = 0;
            plen[c] = 1;
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.out_tready = 1'b1;
        clear_model();
        drive_inputs();
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.out_tready = 1'b1;
        clear_model();
        drive_inputs();
        repeat (2) @(posedge clock);
        #2;
        total_cnt++; if (bus.in_tready !== 4'b0000) $display("FAIL reset_in_tready: got %b want 0000", bus.in_tready); else pass_cnt++;
        total_cnt++; if (bus.out_tvalid !== 1'b0) $display("FAIL reset_out_tvalid: got %b want 0", bus.out_tvalid); else pass_cnt++;
        total_cnt++; if (bus.out_tlast !== 1'b0) $display("FAIL reset_out_tlast: got %b want 0", bus.out_tlast); else pass_cnt++;
        total_cnt++; if (bus.out_tdata !== '0) $display("FAIL reset_out_tdata: got %h want 0", bus.out_tdata[63:0]); else pass_cnt++;
        total_cnt++; if (bus.out_tchannel !== 2'd0) $display("FAIL reset_out_tchannel: got %0d want 0", bus.out_tchannel); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.err_overlong !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err_overlong); else pass_cnt++;
        total_cnt++; if (bus.pkt_count !== 32'd0) $display("FAIL reset_pkt_count: got %0d want 0", bus.pkt_count); else pass_cnt++;
        reset = 1'b0;
        repeat (3) cycle_end();
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL idle_no_req_busy: got %b want 0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_single_packet();
        do_reset();
        plen[1] = 3;
        npk[1]  = 1;
        for (int n = 0; n < 5; n++) begin
            drive_inputs();
            #1;
            if (n == 0 || n == 4) begin
                total_cnt++; if (bus.out_tvalid !== 1'b0 || bus.busy !== 1'b0 || bus.in_tready !== 4'b0000)
                    $display("FAIL single_idle n=%0d: got valid=%b busy=%b rdy=%b want 0 0 0000", n, bus.out_tvalid, bus.busy, bus.in_tready);
                else pass_cnt++;
            end else begin
                total_cnt++; if (bus.out_tvalid !== 1'b1 || bus.busy !== 1'b1 || bus.out_tchannel !== 2'd1 || bus.in_tready !== 4'b0010)
                    $display("FAIL single_beat n=%0d: got valid=%b busy=%b ch=%0d rdy=%b want 1 1 1 0010", n, bus.out_tvalid, bus.busy, bus.out_tchannel, bus.in_tready);
                else pass_cnt++;
                total_cnt++; if (bus.out_tdata !== mk(1, 0, n-1) || bus.out_tlast !== (n == 3))
                    $display("FAIL single_data n=%0d: got %h last=%b want beat %0d last=%b", n, bus.out_tdata[15:0], bus.out_tlast, n-1, (n == 3));
                else pass_cnt++;
            end
            cycle_end();
        end
        total_cnt++; if (bus.pkt_count !== 32'd1 || bus.out_tchannel !== 2'd1)
            $display("FAIL single_done: got pkt=%0d ch=%0d want 1 1", bus.pkt_count, bus.out_tchannel);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            plen[c] = 2;
            npk[c]  = 100;
        end
        for (int n = 0; n < 24; n++) begin
            int ph, ch, pk;
            logic [NUM_CH-1:0] er;
            ph = n % 3;
            ch = (n / 3) % NUM_CH;
            pk = n / 12;
            er = '0;
            if (ph != 0) er[ch] = 1'b1;
            drive_inputs();
            #1;
            total_cnt++; if (bus.out_tvalid !== (ph != 0) || bus.in_tready !== er)
                $display("FAIL rr_valid n=%0d: got valid=%b rdy=%b want %b %b", n, bus.out_tvalid, bus.in_tready, (ph != 0), er);
            else pass_cnt++;
            if (ph != 0) begin
                total_cnt++; if (bus.out_tchannel !== 2'(ch) || bus.out_tdata !== mk(ch, pk, ph-1) || bus.out_tlast !== (ph == 2))
                    $display("FAIL rr_beat n=%0d: got ch=%0d data=%h last=%b want ch=%0d pkt=%0d beat=%0d", n, bus.out_tchannel, bus.out_tdata[15:0], bus.out_tlast, ch, pk, ph-1);
                else pass_cnt++;
            end
            cycle_end();
        end
        total_cnt++; if (bus.pkt_count !== 32'd8) $display("FAIL rr_pkt_count: got %0d want 8", bus.pkt_count); else pass_cnt++;
    endtask

    task automatic test_no_preempt();
        int ev [8] = '{0, 1, 1, 1, 1, 0, 1, 1};
        int ec [8] = '{0, 2, 2, 2, 2, 2, 0, 0};
        int eb [8] = '{0, 0, 1, 2, 3, 0, 0, 1};
        int el [8] = '{0, 0, 0, 0, 1, 0, 0, 1};
        do_reset();
        plen[2] = 4;
        npk[2]  = 1;
        plen[0] = 2;
        for (int n = 0; n < 8; n++) begin
            logic [NUM_CH-1:0] er;
            if (n == 2) npk[0] = 1;
            er = '0;
            if (ev[n] != 0) er[ec[n]] = 1'b1;
            drive_inputs();
            #1;
            total_cnt++; if (bus.out_tvalid !== 1'(ev[n]) || bus.in_tready !== er || bus.out_tchannel !== 2'(ec[n]))
                $display("FAIL preempt_ctl n=%0d: got valid=%b rdy=%b ch=%0d want %0d %b %0d", n, bus.out_tvalid, bus.in_tready, bus.out_tchannel, ev[n], er, ec[n]);
            else pass_cnt++;
            if (ev[n] != 0) begin
                total_cnt++; if (bus.out_tdata !== mk(ec[n], 0, eb[n]) || bus.out_tlast !== 1'(el[n]))
                    $display("FAIL preempt_data n=%0d: got %h last=%b want ch%0d beat%0d last=%0d", n, bus.out_tdata[15:0], bus.out_tlast, ec[n], eb[n], el[n]);
                else pass_cnt++;
            end
            cycle_end();
        end
    endtask

    task automatic test_overlong();
        do_reset();
        plen[3] = 70;
        npk[3]  = 1;
        for (int n = 0; n < 73; n++) begin
            drive_inputs();
            #1;
            if (n >= 1 && n <= 64) begin
                total_cnt++; if (bus.out_tvalid !== 1'b1 || bus.out_tchannel !== 2'd3 || bus.out_tdata !== mk(3, 0, n-1) || bus.out_tlast !== (n == 64))
                    $display("FAIL overlong_beat n=%0d: got v=%b ch=%0d data=%h last=%b want beat %0d", n, bus.out_tvalid, bus.out_tchannel, bus.out_tdata[15:0], bus.out_tlast, n-1);
                else pass_cnt++;
            end else if (n >= 66 && n <= 71) begin
                total_cnt++; if (bus.out_tvalid !== 1'b1 || bus.out_tdata !== mk(3, 0, n-2) || bus.out_tlast !== (n == 71))
                    $display("FAIL overlong_tail n=%0d: got v=%b data=%h last=%b want beat %0d", n, bus.out_tvalid, bus.out_tdata[15:0], bus.out_tlast, n-2);
                else pass_cnt++;
            end else begin
                total_cnt++; if (bus.out_tvalid !== 1'b0 || bus.busy !== 1'b0)
                    $display("FAIL overlong_idle n=%0d: got v=%b busy=%b want 0 0", n, bus.out_tvalid, bus.busy);
                else pass_cnt++;
            end
            if (n == 64) begin
                total_cnt++; if (bus.err_overlong !== 1'b0) $display("FAIL overlong_err_early: got %b want 0", bus.err_overlong); else pass_cnt++;
            end
            if (n == 65) begin
                total_cnt++; if (bus.err_overlong !== 1'b1 || bus.pkt_count !== 32'd1)
                    $display("FAIL overlong_cut: got err=%b pkt=%0d want 1 1", bus.err_overlong, bus.pkt_count);
                else pass_cnt++;
            end
            cycle_end();
        end
        total_cnt++; if (bus.err_overlong !== 1'b1 || bus.pkt_count !== 32'd2)
            $display("FAIL overlong_end: got err=%b pkt=%0d want 1 2", bus.err_overlong, bus.pkt_count);
        else pass_cnt++;
    endtask

    task automatic test_boundary();
        do_reset();
        plen[1] = MAXB;
        npk[1]  = 1;
        for (int n = 0; n < 66; n++) begin
            drive_inputs();
            #1;
            if (n == 63 || n == 64) begin
                total_cnt++; if (bus.out_tdata !== mk(1, 0, n-1) || bus.out_tlast !== (n == 64))
                    $display("FAIL boundary_beat n=%0d: got %h last=%b want beat %0d", n, bus.out_tdata[15:0], bus.out_tlast, n-1);
                else pass_cnt++;
            end
            cycle_end();
        end
        total_cnt++; if (bus.err_overlong !== 1'b0 || bus.pkt_count !== 32'd1 || bus.busy !== 1'b0)
            $display("FAIL boundary_end: got err=%b pkt=%0d busy=%b want 0 1 0", bus.err_overlong, bus.pkt_count, bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int sp [NUM_CH];
        int sb [NUM_CH];
        int stall, got, cyc, c;
        logic prev_hold;
        logic [DW-1:0] pd;
        logic pl;
        logic [1:0] pc;
        do_reset();
        plen[0] = 3; npk[0] = 3;
        plen[2] = 2; npk[2] = 3;
        for (int i = 0; i < NUM_CH; i++) begin
            sp[i] = 0;
            sb[i] = 0;
        end
        stall = 0; got = 0; cyc = 0; prev_hold = 1'b0; pd = '0; pl = 1'b0; pc = 2'd0;
        while (got < 15 && cyc < 4000) begin
            bus.out_tready = (stall == 0);
            drive_inputs();
            #1;
            if (prev_hold) begin
                total_cnt++; if (bus.out_tdata !== pd || bus.out_tlast !== pl || bus.out_tchannel !== pc)
                    $display("FAIL stall_stable cyc=%0d: got %h/%b/%0d want %h/%b/%0d", cyc, bus.out_tdata[15:0], bus.out_tlast, bus.out_tchannel, pd[15:0], pl, pc);
                else pass_cnt++;
            end
            if (bus.out_tvalid && bus.out_tready) begin
                c = int'(bus.out_tchannel);
                total_cnt++; if (bus.out_tdata !== mk(c, sp[c], sb[c]) || bus.out_tlast !== (sb[c] == plen[c] - 1))
                    $display("FAIL stall_order cyc=%0d: got %h last=%b want ch%0d pkt%0d beat%0d", cyc, bus.out_tdata[15:0], bus.out_tlast, c, sp[c], sb[c]);
                else pass_cnt++;
                if (sb[c] == plen[c] - 1) begin
                    sb[c] = 0;
                    sp[c] = sp[c] + 1;
                    stall = $urandom_range(100, 50);
                end else begin
                    sb[c] = sb[c] + 1;
                    stall = $urandom_range(2, 0);
                end
                got++;
            end else if (!bus.out_tready) begin
                stall--;
            end
            prev_hold = bus.out_tvalid && !bus.out_tready;
            pd = bus.out_tdata;
            pl = bus.out_tlast;
            pc = bus.out_tchannel;
            cycle_end();
            cyc++;
        end
        total_cnt++; if (got != 15 || bus.pkt_count !== 32'd6)
            $display("FAIL stall_total: got beats=%0d pkt=%0d want 15 6", got, bus.pkt_count);
        else pass_cnt++;
        bus.out_tready = 1'b1;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        plen[0] = 1; npk[0] = 1;
        plen[1] = 4; npk[1] = 1;
        for (int n = 0; n < 5; n++) begin
            drive_inputs();
            #1;
            if (n == 4) begin
                total_cnt++; if (bus.busy !== 1'b1 || bus.out_tchannel !== 2'd1 || bus.out_tdata !== mk(1, 0, 1))
                    $display("FAIL midrst_pre: got busy=%b ch=%0d data=%h want 1 1 beat1", bus.busy, bus.out_tchannel, bus.out_tdata[15:0]);
                else pass_cnt++;
                reset = 1'b1;
            end
            cycle_end();
        end
        drive_inputs();
        #1;
        total_cnt++; if (bus.in_tready !== 4'b0000 || bus.out_tvalid !== 1'b0 || bus.out_tlast !== 1'b0 || bus.out_tdata !== '0)
            $display("FAIL midrst_datapath: got rdy=%b v=%b l=%b d=%h want all 0", bus.in_tready, bus.out_tvalid, bus.out_tlast, bus.out_tdata[15:0]);
        else pass_cnt++;
        total_cnt++; if (bus.out_tchannel !== 2'd0 || bus.busy !== 1'b0 || bus.pkt_count !== 32'd0 || bus.err_overlong !== 1'b0)
            $display("FAIL midrst_status: got ch=%0d busy=%b pkt=%0d err=%b want 0 0 0 0", bus.out_tchannel, bus.busy, bus.pkt_count, bus.err_overlong);
        else pass_cnt++;
        reset = 1'b0;
        clear_model();
        plen[0] = 1; npk[0] = 1;
        plen[1] = 4; npk[1] = 1;
        drive_inputs();
        cycle_end();
        drive_inputs();
        #1;
        total_cnt++; if (bus.out_tchannel !== 2'd0 || bus.in_tready !== 4'b0001 || bus.out_tdata !== mk(0, 0, 0))
            $display("FAIL midrst_rr: got ch=%0d rdy=%b data=%h want ch0 0001", bus.out_tchannel, bus.in_tready, bus.out_tdata[15:0]);
        else pass_cnt++;
    endtask

    initial begin
        bus.in_tdata   = '0;
        bus.in_tlast   = '0;
        bus.in_tvalid  = '0;
        bus.out_tready = 1'b1;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_no_preempt();
        test_overlong();
        test_boundary();
        test_stall();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end
endmodule
